vme_a16_master: RTL and testbench
=================================

// Module: vme_a16_master
// PURPOSE
//   VME A16/D16 single-cycle bus initiator; the requesting end of the A16 slave protocol used by the adapter boards.
//   Takes one local read/write request and drives AS*, DS0*/DS1*, WRITE*, address, AM and data.
//   Waits for DTACK* or BERR* from the responder, or for an internal timeout, then returns read data and status.
//   Used for bring-up and self-test of slave boards, e.g. reading STATUSID at 0x7CA4.
// PARAMETERS
//   AM_CODE      6'h29  address modifier driven during the cycle (A16 non-privileged)
//   SETUP_CYC    2      clocks that address/AM/WRITE* are valid before AS* falls (min 1)
//   TIMEOUT_CYC  255    clocks in WAIT_ACK with no DTACK*/BERR* before a local bus error (min 4, 8-bit counter)
// PORTS
//   I_CLK_32M       in   1   system clock, 32 MHz
//   I_VME_SYSRESET  in   1   reset, asynchronous, active-high
//   I_REQ           in   1   start request, sampled only in IDLE
//   I_REQ_WR        in   1   1 = write, 0 = read
//   I_REQ_ADDR      in   15  VME address bits [15:1]
//   I_REQ_WDATA     in   16  write data
//   O_BUSY          out  1   high from the cycle after acceptance until the return to IDLE
//   O_DONE          out  1   one-clock pulse when the cycle has finished
//   O_ERR           out  1   valid with O_DONE: 1 = BERR* or timeout
//   O_TIMEOUT       out  1   valid with O_DONE: 1 = internal timeout
//   O_RDATA         out  16  read data, updated only by a successful read
//   O_VME_AS        out  1   AS*, active-low
//   O_VME_DS0       out  1   DS0*, active-low
//   O_VME_DS1       out  1   DS1*, active-low
//   O_VME_WR        out  1   WRITE*, 0 = write, 1 = read
//   O_VME_A         out  15  address [15:1]
//   O_VME_LWORD     out  1   LWORD*, fixed at 1 (D16)
//   O_VME_AM        out  6   address modifier
//   O_VME_D         out  16  write data to the transceiver
//   O_VME_D_OE      out  1   data driver enable, 1 only during write cycles
//   I_VME_D         in   16  read data from the transceiver
//   I_VME_DTACK     in   1   DTACK*, active-low, asynchronous
//   I_VME_BERR      in   1   BERR*, active-low, asynchronous
// BEHAVIOUR
//   Reset values (also forced asynchronously if reset hits mid-cycle):
//     AS*/DS0*/DS1*/WR/LWORD = 1; A, AM, D, RDATA = 0; D_OE, BUSY, DONE, ERR, TIMEOUT = 0.
//     FSM goes to IDLE; no O_DONE is produced for an aborted cycle.
//   DTACK* and BERR* each pass through a 2-flop synchroniser; the FSM uses only the synchronised values.
//   All outputs are registered.
//   States:
//   IDLE: if I_REQ=1, latch address/data/direction.
//     Drive A, AM=AM_CODE and WR; drive D and D_OE=1 if the request is a write.
//     Clear the counter and go to SETUP. I_REQ while not in IDLE is ignored (no queue).
//   SETUP: count SETUP_CYC clocks, then go to STROBE.
//   STROBE: assert AS*=0 for 1 clock, then go to WAIT_ACK.
//   WAIT_ACK: DS0*=DS1*=0 on entry; the counter counts clocks. Checks in priority order:
//     1. BERR sync low -> ERR=1, go to RELEASE.
//     2. DTACK sync low -> on a read, O_RDATA <= I_VME_D; go to RELEASE.
//     3. Counter reaches TIMEOUT_CYC -> ERR=1, TIMEOUT=1, go to RELEASE.
//   RELEASE: set AS*, DS0*, DS1* = 1 and D_OE = 0; clear the counter; go to WAIT_REL.
//   WAIT_REL: wait for synchronised DTACK* and BERR* both high, or TIMEOUT_CYC clocks.
//     Then pulse O_DONE for 1 clock, return to IDLE, and set WR=1.
//     A timeout in WAIT_REL does not change ERR.
//   Timing:
//     AS* first falls SETUP_CYC+1 clocks after acceptance.
//     Address stays stable from SETUP until IDLE.
//     DTACK low seen at a pin edge reaches the FSM 2 clocks later.
//     The next request can be accepted on the clock after O_DONE.
//   ERR/TIMEOUT/RDATA hold their values until the next accepted request clears ERR/TIMEOUT.
// TESTING
//   1. Read 0x7CA4; slave drives 16'hA800 and DTACK* 3 clks after DS* -> O_DONE=1, O_ERR=0, O_RDATA=16'hA800; A[15:1]=15'h3E52, WR=1.
//   2. Write 0x7C88 data 16'h1234 -> D_OE=1 and D=16'h1234 from acceptance through RELEASE; WR=0; DONE with ERR=0; D_OE=0 afterwards.
//   3. No responder -> ERR=1, TIMEOUT=1 after 255 clks in WAIT_ACK; O_RDATA unchanged; AS* high.
//   4. DTACK* and BERR* fall on the same edge -> ERR=1, TIMEOUT=0, O_RDATA unchanged.
//   5. Reset pulsed while in WAIT_ACK -> AS*/DS* high within the same clock; no DONE; a new request runs normally.
//   6. Slave holds DTACK* low 10 clks after AS* rises -> DONE only once DTACK* is high; I_REQ pulsed while BUSY is ignored.

Source files
------------

// File: rtl/vme_a16_master.sv
// VME A16/D16 single-cycle bus initiator: runs one local read or write on the
// backplane and reports read data, bus error and timeout status.
module vme_a16_master #(
    parameter logic [5:0] AM_CODE     = 6'h29,
    parameter int         SETUP_CYC   = 2,
    parameter int         TIMEOUT_CYC = 255
) (
    input  logic        I_CLK_32M,
    input  logic        I_VME_SYSRESET,
    input  logic        I_REQ,
    input  logic        I_REQ_WR,
    input  logic [14:0] I_REQ_ADDR,
    input  logic [15:0] I_REQ_WDATA,
    output logic        O_BUSY,
    output logic        O_DONE,
    output logic        O_ERR,
    output logic        O_TIMEOUT,
    output logic [15:0] O_RDATA,
    output logic        O_VME_AS,
    output logic        O_VME_DS0,
    output logic        O_VME_DS1,
    output logic        O_VME_WR,
    output logic [14:0] O_VME_A,
    output logic        O_VME_LWORD,
    output logic [5:0]  O_VME_AM,
    output logic [15:0] O_VME_D,
    output logic        O_VME_D_OE,
    input  logic [15:0] I_VME_D,
    input  logic        I_VME_DTACK,
    input  logic        I_VME_BERR
);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, WAIT_ACK, RELEASE, WAIT_REL} state_t;

    localparam logic [7:0] SETUP_LAST   = 8'(SETUP_CYC - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYC - 1);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dtackMeta_q, dtackSync_q, berrMeta_q, berrSync_q;
    logic        as_q, as_d, ds_q, ds_d, wr_q, wr_d, dOe_q, dOe_d;
    logic        busy_q, busy_d, done_q, done_d, err_q, err_d, timeout_q, timeout_d;
    logic [14:0] addr_q, addr_d;
    logic [5:0]  am_q, am_d;
    logic [15:0] wdata_q, wdata_d, rdata_q, rdata_d;
    logic        ackSeen, berrSeen, cntExpired, lineReleased;

    assign ackSeen      = !dtackSync_q;
    assign berrSeen     = !berrSync_q;
    assign cntExpired   = (cnt_q == TIMEOUT_LAST);
    assign lineReleased = dtackSync_q && berrSync_q;

    always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
        if (I_VME_SYSRESET) state_q <= IDLE;
        else                state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (I_REQ) state_d = SETUP;
            SETUP:    if (cnt_q == SETUP_LAST) state_d = STROBE;
            STROBE:   state_d = WAIT_ACK;
            WAIT_ACK: if (berrSeen || ackSeen || cntExpired) state_d = RELEASE;
            RELEASE:  state_d = WAIT_REL;
            WAIT_REL: if (lineReleased || cntExpired) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    // Next values for every registered output; BERR wins over DTACK, which wins over the timeout.
    always_comb begin
        cnt_d     = cnt_q;
        as_d      = as_q;
        ds_d      = ds_q;
        wr_d      = wr_q;
        dOe_d     = dOe_q;
        done_d    = 1'b0;
        err_d     = err_q;
        timeout_d = timeout_q;
        addr_d    = addr_q;
        am_d      = am_q;
        wdata_d   = wdata_q;
        rdata_d   = rdata_q;
        busy_d    = (state_d != IDLE);
        case (state_q)
            IDLE: begin
                if (I_REQ) begin
                    addr_d    = I_REQ_ADDR;
                    am_d      = AM_CODE;
                    wr_d      = !I_REQ_WR;
                    err_d     = 1'b0;
                    timeout_d = 1'b0;
                    cnt_d     = 8'd0;
                    if (I_REQ_WR) begin
                        wdata_d = I_REQ_WDATA;
                        dOe_d   = 1'b1;
                    end
                end
            end
            SETUP: cnt_d = cnt_q + 8'd1;
            STROBE: begin
                as_d  = 1'b0;
                cnt_d = 8'd0;
            end
            WAIT_ACK: begin
                ds_d  = 1'b0;
                cnt_d = cnt_q + 8'd1;
                if (berrSeen) begin
                    err_d = 1'b1;
                end else if (ackSeen) begin
                    if (wr_q) rdata_d = I_VME_D;
                end else if (cntExpired) begin
                    err_d     = 1'b1;
                    timeout_d = 1'b1;
                end
            end
            RELEASE: begin
                as_d  = 1'b1;
                ds_d  = 1'b1;
                dOe_d = 1'b0;
                cnt_d = 8'd0;
            end
            WAIT_REL: begin
                cnt_d = cnt_q + 8'd1;
                if (lineReleased || cntExpired) begin
                    done_d = 1'b1;
                    wr_d   = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // DTACK* and BERR* arrive asynchronously from the backplane, so they are double-flopped.
    always_ff @(posedge I_CLK_32M or posedge I_VME_SYSRESET) begin
        if (I_VME_SYSRESET) begin
            dtackMeta_q <= 1'b1;
            dtackSync_q <= 1'b1;
            berrMeta_q  <= 1'b1;
            berrSync_q  <= 1'b1;
            cnt_q       <= 8'd0;
            as_q        <= 1'b1;
            ds_q        <= 1'b1;
            wr_q        <= 1'b1;
            dOe_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            timeout_q   <= 1'b0;
            addr_q      <= 15'd0;
            am_q        <= 6'd0;
            wdata_q     <= 16'd0;
            rdata_q     <= 16'd0;
        end else begin
            dtackMeta_q <= I_VME_DTACK;
            dtackSync_q <= dtackMeta_q;
            berrMeta_q  <= I_VME_BERR;
            berrSync_q  <= berrMeta_q;
            cnt_q       <= cnt_d;
            as_q        <= as_d;
            ds_q        <= ds_d;
            wr_q        <= wr_d;
            dOe_q       <= dOe_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
            timeout_q   <= timeout_d;
            addr_q      <= addr_d;
            am_q        <= am_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
        end
    end

    assign O_BUSY      = busy_q;
    assign O_DONE      = done_q;
    assign O_ERR       = err_q;
    assign O_TIMEOUT   = timeout_q;
    assign O_RDATA     = rdata_q;
    assign O_VME_AS    = as_q;
    assign O_VME_DS0   = ds_q;
    assign O_VME_DS1   = ds_q;
    assign O_VME_WR    = wr_q;
    assign O_VME_A     = addr_q;
    assign O_VME_LWORD = 1'b1;
    assign O_VME_AM    = am_q;
    assign O_VME_D     = wdata_q;
    assign O_VME_D_OE  = dOe_q;

endmodule

// File: tb/tb_vme_a16_master.sv
// Directed bench for vme_a16_master: a small behavioural A16 slave answers each
// cycle, and every scenario task checks its own hand-computed expectations.
`timescale 1ns/1ps
module tb_vme_a16_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        I_REQ, I_REQ_WR;
    logic [14:0] I_REQ_ADDR;
    logic [15:0] I_REQ_WDATA;
    logic        O_BUSY, O_DONE, O_ERR, O_TIMEOUT;
    logic [15:0] O_RDATA;
    logic        O_VME_AS, O_VME_DS0, O_VME_DS1, O_VME_WR, O_VME_LWORD, O_VME_D_OE;
    logic [14:0] O_VME_A;
    logic [5:0]  O_VME_AM;
    logic [15:0] O_VME_D;
    logic [15:0] I_VME_D;
    logic        I_VME_DTACK, I_VME_BERR;

    int compared   = 0;
    int mismatched = 0;

    always #16 clk = ~clk;

    vme_a16_master dut (
        .I_CLK_32M      (clk),
        .I_VME_SYSRESET (rst),
        .I_REQ          (I_REQ),
        .I_REQ_WR       (I_REQ_WR),
        .I_REQ_ADDR     (I_REQ_ADDR),
        .I_REQ_WDATA    (I_REQ_WDATA),
        .O_BUSY         (O_BUSY),
        .O_DONE         (O_DONE),
        .O_ERR          (O_ERR),
        .O_TIMEOUT      (O_TIMEOUT),
        .O_RDATA        (O_RDATA),
        .O_VME_AS       (O_VME_AS),
        .O_VME_DS0      (O_VME_DS0),
        .O_VME_DS1      (O_VME_DS1),
        .O_VME_WR       (O_VME_WR),
        .O_VME_A        (O_VME_A),
        .O_VME_LWORD    (O_VME_LWORD),
        .O_VME_AM       (O_VME_AM),
        .O_VME_D        (O_VME_D),
        .O_VME_D_OE     (O_VME_D_OE),
        .I_VME_D        (I_VME_D),
        .I_VME_DTACK    (I_VME_DTACK),
        .I_VME_BERR     (I_VME_BERR)
    );

    task automatic issueReq(input logic wr, input logic [14:0] addr, input logic [15:0] wdata);
        @(negedge clk);
        I_REQ       = 1'b1;
        I_REQ_WR    = wr;
        I_REQ_ADDR  = addr;
        I_REQ_WDATA = wdata;
        @(negedge clk);
        I_REQ       = 1'b0;
    endtask

    // Behavioural slave: asserts DTACK*/BERR* ackDelay clocks after DS* falls and
    // holds them holdAfterAs clocks after AS* rises; returns at the O_DONE pulse.
    task automatic runSlave(input int ackDelay, input logic doDtack, input logic doBerr,
                            input int holdAfterAs, input logic [15:0] rdVal,
                            output int cyclesToDone, output logic gotDone, output logic earlyDone);
        int   dsWait;
        int   holdCnt;
        logic asserted;
        gotDone      = 1'b0;
        earlyDone    = 1'b0;
        cyclesToDone = 0;
        asserted     = 1'b0;
        holdCnt      = 0;
        dsWait       = 0;
        while (O_VME_DS0 !== 1'b0 && dsWait < 30) begin
            @(negedge clk);
            dsWait++;
        end
        compared++;
        if (O_VME_DS0 !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL ds_assert: DS0* got %b, required 0", O_VME_DS0);
        end else begin
            for (int n = 1; n <= 600 && !gotDone; n++) begin
                @(negedge clk);
                if (O_DONE === 1'b1) begin
                    gotDone      = 1'b1;
                    cyclesToDone = n;
                    earlyDone    = asserted;
                end else if (n == ackDelay && (doDtack || doBerr)) begin
                    I_VME_D = rdVal;
                    if (doDtack) I_VME_DTACK = 1'b0;
                    if (doBerr)  I_VME_BERR  = 1'b0;
                    asserted = 1'b1;
                end else if (asserted && O_VME_AS === 1'b1) begin
                    if (holdCnt >= holdAfterAs) begin
                        I_VME_DTACK = 1'b1;
                        I_VME_BERR  = 1'b1;
                        asserted    = 1'b0;
                    end else begin
                        holdCnt++;
                    end
                end
            end
        end
        I_VME_DTACK = 1'b1;
        I_VME_BERR  = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        compared++;
        if ({O_VME_AS, O_VME_DS0, O_VME_DS1, O_VME_WR, O_VME_LWORD} !== 5'b11111) begin
            mismatched++;
            $display("[TB] FAIL reset_strobes: AS/DS0/DS1/WR/LWORD got %b, required 11111",
                     {O_VME_AS, O_VME_DS0, O_VME_DS1, O_VME_WR, O_VME_LWORD});
        end
        compared++;
        if ({O_VME_A, O_VME_AM, O_VME_D, O_RDATA} !== 53'd0) begin
            mismatched++;
            $display("[TB] FAIL reset_data: A=%h AM=%h D=%h RDATA=%h, required all 0",
                     O_VME_A, O_VME_AM, O_VME_D, O_RDATA);
        end
        compared++;
        if ({O_VME_D_OE, O_BUSY, O_DONE, O_ERR, O_TIMEOUT} !== 5'b00000) begin
            mismatched++;
            $display("[TB] FAIL reset_status: D_OE/BUSY/DONE/ERR/TIMEOUT got %b, required 00000",
                     {O_VME_D_OE, O_BUSY, O_DONE, O_ERR, O_TIMEOUT});
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_read();
        int   k;
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h3E52, 16'h0000);
        compared++;
        if ({O_BUSY, O_VME_WR, O_VME_D_OE, O_VME_AS} !== 4'b1101) begin
            mismatched++;
            $display("[TB] FAIL read_accept: BUSY/WR/D_OE/AS got %b, required 1101",
                     {O_BUSY, O_VME_WR, O_VME_D_OE, O_VME_AS});
        end
        compared++;
        if (O_VME_A !== 15'h3E52 || O_VME_AM !== 6'h29) begin
            mismatched++;
            $display("[TB] FAIL read_addr: A=%h AM=%h, required A=3e52 AM=29", O_VME_A, O_VME_AM);
        end
        k = 0;
        while (O_VME_AS !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (k != 3) begin
            mismatched++;
            $display("[TB] FAIL as_setup: AS* fell after %0d clocks, required 3", k);
        end
        runSlave(3, 1'b1, 1'b0, 0, 16'hA800, cyc, got, early);
        compared++;
        if (got !== 1'b1 || O_ERR !== 1'b0 || O_TIMEOUT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_status: done=%b ERR=%b TIMEOUT=%b, required 1/0/0", got, O_ERR, O_TIMEOUT);
        end
        compared++;
        if (O_RDATA !== 16'hA800) begin
            mismatched++;
            $display("[TB] FAIL read_data: RDATA got %h, required a800", O_RDATA);
        end
        compared++;
        if (O_VME_A !== 15'h3E52 || O_VME_WR !== 1'b1 || O_VME_AS !== 1'b1 || O_BUSY !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL read_end: A=%h WR=%b AS=%b BUSY=%b, required 3e52/1/1/0",
                     O_VME_A, O_VME_WR, O_VME_AS, O_BUSY);
        end
        @(negedge clk);
        compared++;
        if (O_DONE !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL done_pulse: DONE got %b a clock later, required 0", O_DONE);
        end
    endtask

    task automatic test_write();
        int   k;
        int   cyc;
        logic got, early;
        issueReq(1'b1, 15'h3E44, 16'h1234);
        compared++;
        if (O_VME_D_OE !== 1'b1 || O_VME_D !== 16'h1234 || O_VME_WR !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_accept: D_OE=%b D=%h WR=%b, required 1/1234/0", O_VME_D_OE, O_VME_D, O_VME_WR);
        end
        k = 0;
        while (O_VME_AS !== 1'b0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        compared++;
        if (O_VME_D_OE !== 1'b1 || O_VME_D !== 16'h1234 || O_VME_AS !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL write_strobe: D_OE=%b D=%h AS=%b, required 1/1234/0", O_VME_D_OE, O_VME_D, O_VME_AS);
        end
        runSlave(2, 1'b1, 1'b0, 0, 16'hDEAD, cyc, got, early);
        compared++;
        if (got !== 1'b1 || O_ERR !== 1'b0 || O_VME_D_OE !== 1'b0 || O_VME_WR !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL write_end: done=%b ERR=%b D_OE=%b WR=%b, required 1/0/0/1",
                     got, O_ERR, O_VME_D_OE, O_VME_WR);
        end
        compared++;
        if (O_RDATA !== 16'hA800) begin
            mismatched++;
            $display("[TB] FAIL write_rdata: RDATA got %h, required a800", O_RDATA);
        end
    endtask

    task automatic test_timeout();
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h0100, 16'h0000);
        runSlave(0, 1'b0, 1'b0, 0, 16'h0000, cyc, got, early);
        compared++;
        if (got !== 1'b1 || cyc < 255 || cyc > 257) begin
            mismatched++;
            $display("[TB] FAIL timeout_len: done=%b after %0d clocks, required 1 after 255..257", got, cyc);
        end
        compared++;
        if (O_ERR !== 1'b1 || O_TIMEOUT !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_flags: ERR=%b TIMEOUT=%b, required 1/1", O_ERR, O_TIMEOUT);
        end
        compared++;
        if (O_RDATA !== 16'hA800 || O_VME_AS !== 1'b1 || O_VME_DS0 !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL timeout_bus: RDATA=%h AS=%b DS0=%b, required a800/1/1", O_RDATA, O_VME_AS, O_VME_DS0);
        end
    endtask

    task automatic test_berr_dtack();
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h0200, 16'h0000);
        runSlave(2, 1'b1, 1'b1, 0, 16'h5555, cyc, got, early);
        compared++;
        if (got !== 1'b1 || O_ERR !== 1'b1 || O_TIMEOUT !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL berr_prio: done=%b ERR=%b TIMEOUT=%b, required 1/1/0", got, O_ERR, O_TIMEOUT);
        end
        compared++;
        if (O_RDATA !== 16'hA800) begin
            mismatched++;
            $display("[TB] FAIL berr_rdata: RDATA got %h, required a800", O_RDATA);
        end
    endtask

    task automatic test_reset_mid();
        int   k;
        int   doneCnt;
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h0300, 16'h0000);
        k = 0;
        while (O_VME_DS0 !== 1'b0 && k < 30) begin
            @(negedge clk);
            k++;
        end
        repeat (2) @(negedge clk);
        #4 rst = 1'b1;
        #1;
        compared++;
        if ({O_VME_AS, O_VME_DS0, O_VME_DS1, O_BUSY} !== 4'b1110) begin
            mismatched++;
            $display("[TB] FAIL reset_async: AS/DS0/DS1/BUSY got %b, required 1110",
                     {O_VME_AS, O_VME_DS0, O_VME_DS1, O_BUSY});
        end
        repeat (2) @(negedge clk);
        rst = 1'b0;
        doneCnt = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (O_DONE === 1'b1) doneCnt++;
        end
        compared++;
        if (doneCnt != 0) begin
            mismatched++;
            $display("[TB] FAIL reset_nodone: saw %0d DONE pulses, required 0", doneCnt);
        end
        issueReq(1'b0, 15'h0001, 16'h0000);
        runSlave(3, 1'b1, 1'b0, 0, 16'h5A5A, cyc, got, early);
        compared++;
        if (got !== 1'b1 || O_ERR !== 1'b0 || O_RDATA !== 16'h5A5A) begin
            mismatched++;
            $display("[TB] FAIL reset_recover: done=%b ERR=%b RDATA=%h, required 1/0/5a5a", got, O_ERR, O_RDATA);
        end
    endtask

    task automatic test_hold_and_ignore();
        int   busyCnt;
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h0400, 16'h0000);
        @(negedge clk);
        I_REQ      = 1'b1;
        I_REQ_WR   = 1'b1;
        I_REQ_ADDR = 15'h7FFF;
        @(negedge clk);
        I_REQ      = 1'b0;
        compared++;
        if (O_VME_A !== 15'h0400 || O_VME_WR !== 1'b1) begin
            mismatched++;
            $display("[TB] FAIL busy_ignore: A=%h WR=%b, required 0400/1", O_VME_A, O_VME_WR);
        end
        runSlave(3, 1'b1, 1'b0, 10, 16'hC3C3, cyc, got, early);
        compared++;
        if (got !== 1'b1 || early !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL dtack_hold: done=%b early=%b, required 1/0", got, early);
        end
        compared++;
        if (O_RDATA !== 16'hC3C3 || O_ERR !== 1'b0) begin
            mismatched++;
            $display("[TB] FAIL hold_rdata: RDATA=%h ERR=%b, required c3c3/0", O_RDATA, O_ERR);
        end
        busyCnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (O_BUSY === 1'b1) busyCnt++;
        end
        compared++;
        if (busyCnt != 0 || O_VME_A !== 15'h0400) begin
            mismatched++;
            $display("[TB] FAIL no_queue: busy clocks=%0d A=%h, required 0/0400", busyCnt, O_VME_A);
        end
    endtask

    task automatic test_back_to_back();
        int   cyc;
        logic got, early;
        issueReq(1'b0, 15'h0010, 16'h0000);
        runSlave(1, 1'b1, 1'b0, 0, 16'h0F0F, cyc, got, early);
        I_REQ       = 1'b1;
        I_REQ_WR    = 1'b1;
        I_REQ_ADDR  = 15'h0020;
        I_REQ_WDATA = 16'hBEEF;
        @(negedge clk);
        I_REQ       = 1'b0;
        compared++;
        if (O_BUSY !== 1'b1 || O_VME_A !== 15'h0020 || O_VME_WR !== 1'b0 || O_VME_D !== 16'hBEEF) begin
            mismatched++;
            $display("[TB] FAIL b2b_accept: BUSY=%b A=%h WR=%b D=%h, required 1/0020/0/beef",
                     O_BUSY, O_VME_A, O_VME_WR, O_VME_D);
        end
        runSlave(2, 1'b1, 1'b0, 0, 16'h1111, cyc, got, early);
        compared++;
        if (got !== 1'b1 || O_ERR !== 1'b0 || O_RDATA !== 16'h0F0F) begin
            mismatched++;
            $display("[TB] FAIL b2b_end: done=%b ERR=%b RDATA=%h, required 1/0/0f0f", got, O_ERR, O_RDATA);
        end
    endtask

    initial begin
        rst         = 1'b1;
        I_REQ       = 1'b0;
        I_REQ_WR    = 1'b0;
        I_REQ_ADDR  = 15'd0;
        I_REQ_WDATA = 16'd0;
        I_VME_D     = 16'd0;
        I_VME_DTACK = 1'b1;
        I_VME_BERR  = 1'b1;
        test_reset();
        test_read();
        test_write();
        test_timeout();
        test_berr_dtack();
        test_reset_mid();
        test_hold_and_ignore();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
